// File: rtl/timer_entry_pkg.sv
// Shared definitions for the timer-entry keypad path: default sizing,
// FSM state encoding and the one-hot to binary helper.
package timer_entry_pkg;

    localparam int DEF_N_KEYS          = 10;
    localparam int DEF_CODE_W          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam logic [DEF_CODE_W-1:0] INVALID_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    // Index of the set bit; for a one-hot input the result is unambiguous.
    function automatic logic [31:0] onehot_to_code(input logic [31:0] vec);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_classifier.sv
// Combinational classification of a key sample as empty, single key or
// multiple keys, with the binary index of a single key.
module onehot_classifier
    import timer_entry_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS,
    parameter int CODE_W = DEF_CODE_W
) (
    input  logic [N_KEYS-1:0] s,
    output logic              is_zero,
    output logic              is_onehot,
    output logic              is_multi,
    output logic [CODE_W-1:0] code
);

    logic [31:0] code_full;

    assign is_zero   = (s == '0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign is_multi  = ((s & (s - 1'b1)) != '0);
    assign is_onehot = !is_zero && !is_multi;
    assign code_full = onehot_to_code(32'(s));
    assign code      = code_full[CODE_W-1:0];

endmodule

// File: rtl/debounced_key_encoder.sv
// Synchronising, debouncing keypad encoder producing one handshaked key
// event per physical press, with multi-key and overrun indication.
module debounced_key_encoder
    import timer_entry_pkg::*;
#(
    parameter int                N_KEYS          = DEF_N_KEYS,
    parameter int                CODE_W          = DEF_CODE_W,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CODE_W-1:0] INVALID_CODE    = '1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_KEYS-1:0] keypad,
    input  logic              enablen,
    input  logic              key_ack,
    output logic [CODE_W-1:0] D,
    output logic              key_ready,
    output logic              overrun,
    output logic              multi_key,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_KEYS-1:0] sync1_reg, sync2_reg;
    logic [N_KEYS-1:0] cand_reg, cand_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    key_state_e        state_reg, state_next;
    logic [CODE_W-1:0] d_reg;
    logic              ready_reg, overrun_reg, multi_reg, busy_reg;
    logic              is_zero, is_onehot, is_multi;
    logic [CODE_W-1:0] code;
    logic              count_done;
    logic              accept;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= keypad;
            sync2_reg <= sync1_reg;
        end
    end

    onehot_classifier #(
        .N_KEYS (N_KEYS),
        .CODE_W (CODE_W)
    ) u_classifier (
        .s         (sync2_reg),
        .is_zero   (is_zero),
        .is_onehot (is_onehot),
        .is_multi  (is_multi),
        .code      (code)
    );

    assign cnt_inc    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    // True when the current matching sample is the one that completes the window.
    assign count_done = (int'(cnt_reg) + 1 >= DEBOUNCE_CYCLES);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        accept     = 1'b0;
        if (enablen) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_onehot) begin
                        cand_next = sync2_reg;
                        if (DEBOUNCE_CYCLES <= 1) begin
                            state_next = ST_PRESSED;
                            cnt_next   = '0;
                            accept     = 1'b1;
                        end else begin
                            state_next = ST_DEBOUNCE;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sync2_reg == cand_reg) begin
                        if (count_done) begin
                            state_next = ST_PRESSED;
                            cnt_next   = '0;
                            accept     = 1'b1;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (is_zero) begin
                        state_next = (DEBOUNCE_CYCLES <= 1) ? ST_IDLE : ST_RELEASE;
                        cnt_next   = (DEBOUNCE_CYCLES <= 1) ? '0 : CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!is_zero) begin
                        state_next = ST_PRESSED;
                        cnt_next   = '0;
                    end else if (count_done) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            cand_reg    <= '0;
            d_reg       <= INVALID_CODE;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            multi_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            multi_reg <= is_multi;
            busy_reg  <= (state_next != ST_IDLE);
            // An ack landing with a new event consumes the old one, so no overrun.
            if (accept) begin
                d_reg     <= code;
                ready_reg <= 1'b1;
                if (ready_reg && !key_ack) overrun_reg <= 1'b1;
                else if (ready_reg && key_ack) overrun_reg <= 1'b0;
            end else if (ready_reg && key_ack) begin
                ready_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
        end
    end

    assign D         = d_reg;
    assign key_ready = ready_reg;
    assign overrun   = overrun_reg;
    assign multi_key = multi_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_debounced_key_encoder.sv
// Directed bench for debounced_key_encoder with default parameters:
// inputs change and outputs are checked on the falling clock edge.
module tb_debounced_key_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  keypad;
    logic        enablen;
    logic        key_ack;
    logic [3:0]  D;
    logic        key_ready;
    logic        overrun;
    logic        multi_key;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounced_key_encoder dut (
        .clk       (clk),
        .rstn      (rstn),
        .keypad    (keypad),
        .enablen   (enablen),
        .key_ack   (key_ack),
        .D         (D),
        .key_ready (key_ready),
        .overrun   (overrun),
        .multi_key (multi_key),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; keypad = '0; enablen = 1'b0; key_ack = 1'b0;
        tick(2);
        chk("rst_D", 32'(D), 32'hF);
        chk("rst_ready", 32'(key_ready), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_multi", 32'(multi_key), 0);
        chk("rst_busy", 32'(busy), 0);
        rstn = 1'b1;

        // clean press of key 7
        keypad = 10'd1 << 7;
        tick(5);
        chk("k7_ready_e5", 32'(key_ready), 0);
        chk("k7_busy_e5", 32'(busy), 1);
        tick(1);
        chk("k7_ready_e6", 32'(key_ready), 1);
        chk("k7_D", 32'(D), 7);
        tick(4);
        keypad = '0;
        tick(10);
        chk("k7_ready_hold", 32'(key_ready), 1);
        chk("k7_no_second", 32'(overrun), 0);
        chk("k7_idle", 32'(busy), 0);
        ack_pulse();
        chk("k7_ack_ready", 32'(key_ready), 0);
        chk("k7_ack_D", 32'(D), 7);

        // bouncing press of key 3
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? (10'd1 << 3) : 10'd0;
            tick(1);
            chk("k3_bounce", 32'(key_ready), 0);
        end
        keypad = 10'd1 << 3;
        tick(5);
        chk("k3_ready_e5", 32'(key_ready), 0);
        tick(1);
        chk("k3_ready_e6", 32'(key_ready), 1);
        chk("k3_D", 32'(D), 3);
        ack_pulse();
        chk("k3_ack", 32'(key_ready), 0);
        tick(3);
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? 10'd0 : (10'd1 << 3);
            tick(1);
        end
        keypad = '0;
        tick(10);
        chk("k3_rel_ready", 32'(key_ready), 0);
        chk("k3_rel_overrun", 32'(overrun), 0);
        chk("k3_rel_busy", 32'(busy), 0);

        // keys 2 and 5 together, then only key 2
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        keypad = (10'd1 << 2) | (10'd1 << 5);
        tick(3);
        chk("mk_multi", 32'(multi_key), 1);
        tick(5);
        chk("mk_ready", 32'(key_ready), 0);
        chk("mk_busy", 32'(busy), 0);
        chk("mk_D", 32'(D), 32'hF);
        keypad = 10'd1 << 2;
        tick(5);
        chk("mk_k2_e5", 32'(key_ready), 0);
        tick(1);
        chk("mk_k2_ready", 32'(key_ready), 1);
        chk("mk_k2_D", 32'(D), 2);
        chk("mk_multi_clr", 32'(multi_key), 0);
        keypad = '0;
        ack_pulse();
        tick(10);

        // overrun: key 1 unacked, then key 9
        keypad = 10'd1 << 1;
        tick(6);
        chk("ov_k1_ready", 32'(key_ready), 1);
        chk("ov_k1_D", 32'(D), 1);
        tick(2);
        keypad = '0;
        tick(8);
        keypad = 10'd1 << 9;
        tick(5);
        chk("ov_pre_D", 32'(D), 1);
        chk("ov_pre_flag", 32'(overrun), 0);
        tick(1);
        chk("ov_D", 32'(D), 9);
        chk("ov_ready", 32'(key_ready), 1);
        chk("ov_flag", 32'(overrun), 1);
        ack_pulse();
        chk("ov_ack_ready", 32'(key_ready), 0);
        chk("ov_ack_flag", 32'(overrun), 0);
        keypad = '0;
        tick(8);

        // same again, but ack lands on the key-9 acceptance edge
        keypad = 10'd1 << 1;
        tick(6);
        chk("oa_k1_ready", 32'(key_ready), 1);
        tick(2);
        keypad = '0;
        tick(8);
        keypad = 10'd1 << 9;
        tick(5);
        ack_pulse();
        chk("oa_ready", 32'(key_ready), 1);
        chk("oa_D", 32'(D), 9);
        chk("oa_flag", 32'(overrun), 0);
        ack_pulse();
        chk("oa_ack_ready", 32'(key_ready), 0);
        keypad = '0;
        tick(8);

        // enable dropped during debounce of key 4
        keypad = 10'd1 << 4;
        tick(4);
        chk("en_busy_deb", 32'(busy), 1);
        enablen = 1'b1;
        tick(1);
        chk("en_busy_off", 32'(busy), 0);
        tick(5);
        chk("en_no_event", 32'(key_ready), 0);
        chk("en_D_kept", 32'(D), 9);
        enablen = 1'b0;
        tick(3);
        chk("en_k4_e3", 32'(key_ready), 0);
        tick(1);
        chk("en_k4_ready", 32'(key_ready), 1);
        chk("en_k4_D", 32'(D), 4);

        // reset while PRESSED with a pending overrun
        keypad = '0;
        tick(8);
        keypad = 10'd1 << 4;
        tick(6);
        chk("rs_pre_overrun", 32'(overrun), 1);
        chk("rs_pre_ready", 32'(key_ready), 1);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("rs_D", 32'(D), 32'hF);
        chk("rs_ready", 32'(key_ready), 0);
        chk("rs_overrun", 32'(overrun), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_multi", 32'(multi_key), 0);
        tick(5);
        chk("rs_k4_e5", 32'(key_ready), 0);
        tick(1);
        chk("rs_k4_ready", 32'(key_ready), 1);
        chk("rs_k4_D", 32'(D), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
